// File: rtl/axi4_lite_write_slave.sv
// Purpose: AXI4-Lite write responder, one transaction at a time, commits to a sync memory write port.
// Latency: last AW/W handshake in cycle N -> mem_wen in N+1, B_VALID in N+2 (N+1 on error/zero-strobe).
// Backpressure: AW/W held off from capture until B handshake; mem_wready and B_READY stall in place.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   AW_ADDR/AW_VALID/AW_READY write address channel
//   W_DATA/W_STRB/W_VALID/W_READY write data channel
//   B_RESP/B_VALID/B_READY    write response channel (00 OKAY, 10 SLVERR)
//   mem_wen/mem_waddr/mem_wdata/mem_wmask/mem_wready  memory write port
//
// All outputs are decoded from registered state; rst only gates them to zero.
module axi4_lite_write_slave #(
  parameter int unsigned         ADDR_W     = 64,
  parameter int unsigned         DATA_W     = 64,
  parameter logic [ADDR_W-1:0]   BASE_ADDR  = 64'h8000_0000,
  parameter logic [ADDR_W-1:0]   SIZE_BYTES = 64'h0800_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address channel
  input  logic [ADDR_W-1:0]     AW_ADDR,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  // write data channel
  input  logic [DATA_W-1:0]     W_DATA,
  input  logic [DATA_W/8-1:0]   W_STRB,
  input  logic                  W_VALID,
  output logic                  W_READY,
  // write response channel
  output logic [1:0]            B_RESP,
  output logic                  B_VALID,
  input  logic                  B_READY,
  // memory write port
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_wready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB_W  = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Mask that clears the byte-offset bits inside one data beat.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-LSB_W){1'b0}}, {LSB_W{1'b1}}};

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WRITE   = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_aw_held;
  logic                r_w_held;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DATA_W-1:0]   r_data_q;
  logic [STRB_W-1:0]   r_strb_q;
  logic [1:0]          r_resp_q;
  logic [1:0]          w_resp_nxt;
  logic                w_clr_held;

  // Internal readiness, not gated by rst; the reset edge overrides any capture anyway.
  logic                w_aw_rdy;
  logic                w_w_rdy;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_both;
  logic [ADDR_W-1:0]   w_addr_eff;
  logic [STRB_W-1:0]   w_strb_eff;
  logic [ADDR_W-1:0]   w_offset;
  logic                w_in_win;

  assign w_aw_rdy = (r_state == S_COLLECT) && !r_aw_held;
  assign w_w_rdy  = (r_state == S_COLLECT) && !r_w_held;
  assign w_aw_hs  = AW_VALID && w_aw_rdy;
  assign w_w_hs   = W_VALID && w_w_rdy;

  // Decode uses the values that will be held after this edge, so a capture
  // made on the exit edge itself is taken into account.
  assign w_both     = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_addr_eff = w_aw_hs ? AW_ADDR : r_addr_q;
  assign w_strb_eff = w_w_hs ? W_STRB : r_strb_q;

  // Full-width unsigned subtract: addresses below BASE_ADDR are rejected by
  // the first term, so the offset never wraps into the window.
  assign w_offset = w_addr_eff - BASE_ADDR;
  assign w_in_win = (w_addr_eff >= BASE_ADDR) && (w_offset < SIZE_BYTES);

  // State and captured transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_COLLECT;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_addr_q  <= '0;
      r_data_q  <= '0;
      r_strb_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state  <= w_state_nxt;
      r_resp_q <= w_resp_nxt;
      if (w_clr_held) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_addr_q  <= AW_ADDR;
          r_aw_held <= 1'b1;
        end
        if (w_w_hs) begin
          r_data_q <= W_DATA;
          r_strb_q <= W_STRB;
          r_w_held <= 1'b1;
        end
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_resp_nxt  = r_resp_q;
    w_clr_held  = 1'b0;
    AW_READY    = 1'b0;
    W_READY     = 1'b0;
    B_VALID     = 1'b0;
    B_RESP      = RESP_OKAY;
    mem_wen     = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;

    case (r_state)
      S_COLLECT: begin
        AW_READY = w_aw_rdy && !rst;
        W_READY  = w_w_rdy && !rst;
        if (w_both) begin
          if (!w_in_win) begin
            w_state_nxt = S_RESP;
            w_resp_nxt  = RESP_SLVERR;
          end else if (w_strb_eff == '0) begin
            // Nothing to write: acknowledge without touching memory.
            w_state_nxt = S_RESP;
            w_resp_nxt  = RESP_OKAY;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (!rst) begin
          mem_wen   = 1'b1;
          mem_waddr = r_addr_q & ALIGN_MASK;
          mem_wdata = r_data_q;
          mem_wmask = r_strb_q;
        end
        if (mem_wready) begin
          w_state_nxt = S_RESP;
          w_resp_nxt  = RESP_OKAY;
        end
      end

      S_RESP: begin
        if (!rst) begin
          B_VALID = 1'b1;
          B_RESP  = r_resp_q;
        end
        if (B_READY) begin
          w_state_nxt = S_COLLECT;
          w_clr_held  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

endmodule
